// File: rtl/config_pkg.sv
// Minimal core configuration type used to size the branch predictor.
// Only the fetch width is needed by the predictor RAM controller.
package config_pkg;

    typedef struct packed {
        int unsigned INSTR_PER_FETCH;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '{INSTR_PER_FETCH: 32'd2};

endpackage

// File: rtl/gbp_pkg.sv
// Shared definitions for the global branch predictor RAM controller:
// controller state, default table parameters and index-width helper.
package gbp_pkg;

    // Controller state: table sweep in progress, or normal operation.
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } gbp_state_e;

    // Weakly not-taken for a 2-bit saturating counter.
    localparam int unsigned GBP_INIT_CTR  = 1;
    localparam int unsigned GBP_CTR_BITS  = 2;
    localparam int unsigned GBP_NR_ROWS   = 64;
    localparam int unsigned GBP_UPD_DEPTH = 2;

    // Index width that stays legal (>= 1 bit) for single-entry arrays.
    function automatic int unsigned gbp_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gbp_upd_fifo.sv
// Write-back FIFO for counter updates; synchronous, flushable.
// Ports: clk_i/rst_ni, flush_i, push_i/data_i, pop_i/data_o, full_o, empty_o.
module gbp_upd_fifo
    import gbp_pkg::*;
#(
    parameter type         T     = logic,
    parameter int unsigned DEPTH = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic flush_i,
    input  logic push_i,
    input  T     data_i,
    input  logic pop_i,
    output T     data_o,
    output logic full_o,
    output logic empty_o
);

    localparam int unsigned AW = gbp_idx_w(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    T               mem_q [DEPTH];
    logic [AW-1:0]  wr_q;
    logic [AW-1:0]  rd_q;
    logic [CW-1:0]  cnt_q;
    logic           do_push;
    logic           do_pop;
    logic [AW-1:0]  wr_nxt;
    logic [AW-1:0]  rd_nxt;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);

    // A push into a full FIFO is legal when the head leaves this cycle.
    assign do_push = push_i && (!full_o || pop_i);
    assign do_pop  = pop_i && !empty_o;

    assign wr_nxt = (wr_q == AW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
    assign rd_nxt = (rd_q == AW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;

    assign data_o = mem_q[rd_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= wr_nxt;
            end
            if (do_pop) begin
                rd_q <= rd_nxt;
            end
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/gbp_ram_ctrl.sv
// Counter-RAM controller/arbiter for the global branch predictor.
// Ports: flush/debug control, read req/gnt/valid, write-back handshake,
// per-bank RAM req/we/addr/wdata, init_done_o.
module gbp_ram_ctrl
    import gbp_pkg::*;
#(
    parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
    parameter int unsigned NR_ROWS   = GBP_NR_ROWS,
    parameter int unsigned CTR_BITS  = GBP_CTR_BITS,
    parameter int unsigned INIT_CTR  = GBP_INIT_CTR,
    parameter int unsigned UPD_DEPTH = GBP_UPD_DEPTH,
    localparam int unsigned NB = CVA6Cfg.INSTR_PER_FETCH,
    localparam int unsigned RW = $clog2(NR_ROWS),
    localparam int unsigned BW = gbp_idx_w(NB)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_bp_i,
    input  logic                   debug_mode_i,
    input  logic                   rd_req_i,
    input  logic [RW-1:0]          rd_row_i,
    output logic                   rd_gnt_o,
    output logic                   rd_valid_o,
    input  logic                   upd_valid_i,
    input  logic [RW-1:0]          upd_row_i,
    input  logic [BW-1:0]          upd_bank_i,
    input  logic [CTR_BITS-1:0]    upd_ctr_i,
    output logic                   upd_ready_o,
    output logic [NB-1:0]          ram_req_o,
    output logic [NB-1:0]          ram_we_o,
    output logic [NB*RW-1:0]       ram_addr_o,
    output logic [NB*CTR_BITS-1:0] ram_wdata_o,
    output logic                   init_done_o
);

    typedef struct packed {
        logic [RW-1:0]       row;
        logic [BW-1:0]       bank;
        logic [CTR_BITS-1:0] ctr;
    } upd_t;

    gbp_state_e          state_q;
    logic [RW-1:0]       row_q;
    logic                rd_valid_q;
    logic                init_done_q;

    upd_t                push_data;
    upd_t                head;
    logic                push;
    logic                pop;
    logic                full;
    logic                empty;

    logic                gnt;
    logic                rdy;
    logic                wr_issue;
    logic [NB-1:0]       bank_oh;
    logic [RW-1:0]       sel_row;
    logic [CTR_BITS-1:0] sel_data;

    assign push_data = '{row: upd_row_i, bank: upd_bank_i, ctr: upd_ctr_i};
    assign bank_oh   = NB'(1) << head.bank;

    gbp_upd_fifo #(
        .T     (upd_t),
        .DEPTH (UPD_DEPTH)
    ) i_upd_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_bp_i),
        .push_i  (push),
        .data_i  (push_data),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (full),
        .empty_o (empty)
    );

    // Arbiter: a full FIFO wins over reads so write-backs cannot starve;
    // otherwise reads win and writes fill idle cycles.
    always_comb begin
        ram_req_o = '0;
        ram_we_o  = '0;
        gnt       = 1'b0;
        rdy       = 1'b1;
        wr_issue  = 1'b0;
        pop       = 1'b0;
        push      = 1'b0;
        sel_row   = rd_row_i;
        sel_data  = head.ctr;
        unique case (state_q)
            ST_CLEAR: begin
                // Write-backs are acknowledged but dropped: the sweep
                // overwrites the whole table anyway.
                ram_req_o = '1;
                ram_we_o  = '1;
                sel_row   = row_q;
                sel_data  = CTR_BITS'(INIT_CTR);
            end
            ST_RUN: begin
                wr_issue = full || (!rd_req_i && !empty);
                gnt      = rd_req_i && !full;
                rdy      = !full || wr_issue;
                pop      = wr_issue;
                push     = upd_valid_i && rdy && !debug_mode_i;
                if (wr_issue) begin
                    ram_req_o = bank_oh;
                    ram_we_o  = bank_oh;
                    sel_row   = head.row;
                end else if (gnt) begin
                    ram_req_o = '1;
                end
            end
            default: ;
        endcase
    end

    assign rd_gnt_o    = gnt;
    assign upd_ready_o = rdy;
    assign ram_addr_o  = {NB{sel_row}};
    assign ram_wdata_o = {NB{sel_data}};
    assign rd_valid_o  = rd_valid_q;
    assign init_done_o = init_done_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_CLEAR;
            row_q       <= '0;
            rd_valid_q  <= 1'b0;
            init_done_q <= 1'b0;
        end else if (flush_bp_i) begin
            state_q     <= ST_CLEAR;
            row_q       <= '0;
            rd_valid_q  <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            rd_valid_q <= gnt;
            unique case (state_q)
                ST_CLEAR: begin
                    // Row counter wraps to 0 on the last row (power of 2).
                    row_q <= row_q + 1'b1;
                    if (row_q == RW'(NR_ROWS - 1)) begin
                        state_q     <= ST_RUN;
                        init_done_q <= 1'b1;
                    end
                end
                ST_RUN: ;
                default: begin
                    state_q     <= ST_CLEAR;
                    row_q       <= '0;
                    init_done_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
